// File: rtl/fsm_seq_pkg.sv
// Shared encodings and helpers for the N-state sequencer.
package fsm_seq_pkg;

  typedef enum logic {
    MODE_WRAP   = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Out-of-range preload values saturate to the last legal state.
  function automatic int unsigned clamp_state(input int unsigned val,
                                              input int unsigned num_states);
    return (val >= num_states) ? (num_states - 1) : val;
  endfunction

endpackage

// File: rtl/fsm_dwell_timer.sv
// Per-state dwell counter: asserts adv on the enabled cycle that ends a dwell.
module fsm_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic               adv
);

  logic [DWELL_W-1:0] r_cnt;
  logic               w_done;

  // >= rather than == so that shrinking dwell_cycles mid-dwell advances at once.
  assign w_done = (r_cnt >= dwell_cycles);
  assign adv    = en & ~clr & w_done;

  // Count enabled cycles; restart on preload or at the end of each dwell.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_done) r_cnt <= '0;
      else        r_cnt <= r_cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/fsm_nstate_seq.sv
// Parametrised N-state sequencer with wrap/bounce modes, preload and pause.
module fsm_nstate_seq
  import fsm_seq_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int STATE_W    = $clog2(NUM_STATES),
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               load,
  input  logic [STATE_W-1:0] load_state,
  output logic [STATE_W-1:0] state_out,
  output logic               dir_out,
  output logic               wrap_pulse
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

  if (NUM_STATES < 2) begin : g_bad_num_states
    $error("fsm_nstate_seq: NUM_STATES must be >= 2");
  end

  logic [STATE_W-1:0] r_state;
  dir_e               r_dir;
  logic               r_wrap;

  logic               w_adv;
  logic [STATE_W-1:0] w_load_state;
  logic [STATE_W-1:0] w_next_state;
  dir_e               w_next_dir;
  logic               w_next_wrap;

  fsm_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clr          (load),
    .dwell_cycles (dwell_cycles),
    .adv          (w_adv)
  );

  assign w_load_state = STATE_W'(clamp_state(32'(load_state), NUM_STATES));

  // Next state, direction and boundary flag for the coming advance.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next_state = r_state;
    w_next_dir   = r_dir;
    w_next_wrap  = 1'b0;
    if (mode_e'(mode) == MODE_WRAP) begin
      w_next_dir = dir_e'(dir);
      if (dir_e'(dir) == DIR_UP) begin
        if (r_state == LAST_STATE) begin
          w_next_state = '0;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_state = r_state + STATE_W'(1);
        end
      end else begin
        if (r_state == '0) begin
          w_next_state = LAST_STATE;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_state = r_state - STATE_W'(1);
        end
      end
    end else begin
      // Bounce: turn around at either end so endpoints are never repeated.
      if (r_dir == DIR_UP) begin
        if (r_state == LAST_STATE) begin
          w_next_state = LAST_STATE - STATE_W'(1);
          w_next_dir   = DIR_DOWN;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_state = r_state + STATE_W'(1);
        end
      end else begin
        if (r_state == '0) begin
          w_next_state = STATE_W'(1);
          w_next_dir   = DIR_UP;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_state = r_state - STATE_W'(1);
        end
      end
    end
  end

  // Output registers: reset > load > advance > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_dir   <= DIR_UP;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_state <= w_load_state;
      r_dir   <= dir_e'(dir);
      r_wrap  <= 1'b0;
    end else if (w_adv) begin
      r_state <= w_next_state;
      r_dir   <= w_next_dir;
      r_wrap  <= w_next_wrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign state_out  = r_state;
  assign dir_out    = r_dir;
  assign wrap_pulse = r_wrap;

endmodule
